// File: rtl/mixer_ch_sched_pkg.sv
// Shared sizing defaults for the multichannel mixer scheduler.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package mixer_ch_sched_pkg;

  localparam int NCH_DEF      = 4;   // input channels sharing one mixer
  localparam int PW_DEF       = 32;  // phase accumulator width
  localparam int PIPE_LAT_DEF = 3;   // issue-to-result latency of the mixer
  localparam int SAMP_W       = 16;  // input sample width
  localparam int RES_W        = 20;  // mixer result width

  // Channel-index width; a single channel still needs a 1-bit tag.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mixer_ch_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant over req_i, search starts after last grant.
// Latency: combinational grant, pointer updates on the clock after a grant.
// Backpressure: none; no request -> no grant and the pointer holds.
// Ports: clk/rst, req_i[N], gnt_o[N] one-hot, gnt_idx_o encoded grant.
module rr_arb
  import mixer_ch_sched_pkg::*;
#(
  parameter int N = NCH_DEF,
  localparam int IW = ch_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mixer_ch_sched.sv
// Time-shares one I/Q mixer/NCO among NCH channels, each with its own phase accumulator.
// Latency: accept -> grant next cycle -> mix_* one cycle later; out_* PIPE_LAT+1 after issue.
// Backpressure: per-channel 1-deep hold; in_ready = !hold_v | grant, no grants while en=0.
// Ports: en, in_valid/in_data/in_ready (inputs), cfg_* (freq word / phase clear),
//        mix_valid/mix_data/mix_phase (to mixer), res_i/res_q (from mixer),
//        out_valid/out_ch/out_i/out_q (tagged results).
module mixer_ch_sched
  import mixer_ch_sched_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int PW       = PW_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  localparam int CW = ch_w(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCH-1:0]        in_valid,
  input  logic [SAMP_W*NCH-1:0] in_data,
  output logic [NCH-1:0]        in_ready,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_ch,
  input  logic [PW-1:0]         cfg_fword,
  input  logic                  cfg_ph_clr,
  output logic                  mix_valid,
  output logic [SAMP_W-1:0]     mix_data,
  output logic [PW-1:0]         mix_phase,
  input  logic [RES_W-1:0]      res_i,
  input  logic [RES_W-1:0]      res_q,
  output logic                  out_valid,
  output logic [CW-1:0]         out_ch,
  output logic [RES_W-1:0]      out_i,
  output logic [RES_W-1:0]      out_q
);

  logic [NCH-1:0]    hold_v_q, hold_v_d;
  logic [SAMP_W-1:0] hold_q  [NCH];
  logic [PW-1:0]     acc_q   [NCH];
  logic [PW-1:0]     acc_d   [NCH];
  logic [PW-1:0]     fword_q [NCH];

  logic [NCH-1:0] grant;
  logic [CW-1:0]  gnt_idx;
  logic [NCH-1:0] accept;

  logic              mix_valid_q;
  logic [CW-1:0]     mix_ch_q;
  logic [SAMP_W-1:0] mix_data_q;
  logic [PW-1:0]     mix_phase_q;

  logic          tag_v_q  [PIPE_LAT];
  logic [CW-1:0] tag_ch_q [PIPE_LAT];

  logic              out_valid_q;
  logic [CW-1:0]     out_ch_q;
  logic [RES_W-1:0]  out_i_q, out_q_q;

  // Gating requests with en keeps the arbiter pointer frozen while disabled.
  rr_arb #(.N(NCH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (hold_v_q & {NCH{en}}),
    .gnt_o     (grant),
    .gnt_idx_o (gnt_idx)
  );

  // A granted slot is vacated this cycle, so it can refill at the same edge.
  assign in_ready = rst ? '0 : (~hold_v_q | grant);
  assign accept   = in_valid & in_ready;

  always_comb begin
    hold_v_d = hold_v_q;
    for (int c = 0; c < NCH; c++) begin
      acc_d[c] = acc_q[c];
      if (accept[c])     hold_v_d[c] = 1'b1;
      else if (grant[c]) hold_v_d[c] = 1'b0;
      // Clear wins over the increment; the issued phase is still the old value.
      if (cfg_ph_clr && int'(cfg_ch) == c) acc_d[c] = '0;
      else if (grant[c])                  acc_d[c] = acc_q[c] + fword_q[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        hold_q[c]  <= '0;
        acc_q[c]   <= '0;
        fword_q[c] <= '0;
      end
    end else begin
      hold_v_q <= hold_v_d;
      for (int c = 0; c < NCH; c++) begin
        acc_q[c] <= acc_d[c];
        if (accept[c]) hold_q[c] <= in_data[SAMP_W*c +: SAMP_W];
        // The grant in this cycle already used the old word.
        if (cfg_we && int'(cfg_ch) == c) fword_q[c] <= cfg_fword;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_valid_q <= 1'b0;
      mix_ch_q    <= '0;
      mix_data_q  <= '0;
      mix_phase_q <= '0;
    end else begin
      mix_valid_q <= |grant;
      if (|grant) begin
        mix_ch_q    <= gnt_idx;
        mix_data_q  <= hold_q[gnt_idx];
        mix_phase_q <= acc_q[gnt_idx];
      end
    end
  end

  // Tag line mirrors the mixer pipeline so results can be attributed to a channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_v_q[k]  <= 1'b0;
        tag_ch_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      tag_v_q[0]  <= mix_valid_q;
      tag_ch_q[0] <= mix_ch_q;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_ch_q[k] <= tag_ch_q[k-1];
      end
      out_valid_q <= tag_v_q[PIPE_LAT-1];
      out_ch_q    <= tag_ch_q[PIPE_LAT-1];
      out_i_q     <= res_i;
      out_q_q     <= res_q;
    end
  end

  assign mix_valid = mix_valid_q;
  assign mix_data  = mix_data_q;
  assign mix_phase = mix_phase_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;

endmodule

// File: tb/tb_mixer_ch_sched.sv
// Directed bench for mixer_ch_sched with default parameters (NCH=4, PW=32, PIPE_LAT=3).
module tb_mixer_ch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_fword;
  logic        cfg_ph_clr;
  logic        mix_valid;
  logic [15:0] mix_data;
  logic [31:0] mix_phase;
  logic [19:0] res_i, res_q;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [19:0] out_i, out_q;

  int n_chk = 0;
  int n_err = 0;

  mixer_ch_sched dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_fword(cfg_fword), .cfg_ph_clr(cfg_ph_clr),
    .mix_valid(mix_valid), .mix_data(mix_data), .mix_phase(mix_phase),
    .res_i(res_i), .res_q(res_q),
    .out_valid(out_valid), .out_ch(out_ch), .out_i(out_i), .out_q(out_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; in_valid = '0; in_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_fword = '0; cfg_ph_clr = 1'b0;
    res_i = '0; res_q = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_fword(input logic [1:0] ch, input logic [31:0] fw);
    cfg_we = 1'b1; cfg_ch = ch; cfg_fword = fw;
    tick();
    cfg_we = 1'b0;
  endtask

  // Present one sample, let it be accepted, then wait for its issue cycle.
  task automatic issue_one(input int ch, input logic [15:0] d);
    in_valid = 4'b0001 << ch;
    in_data[16*ch +: 16] = d;
    tick();
    in_valid = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 4'hF; in_data = '1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_fword = '0; cfg_ph_clr = 1'b0;
    res_i = 20'h12345; res_q = 20'h54321;
    tick(); tick();
    n_chk++; if (in_ready !== 4'h0) begin n_err++; $display("FAIL rst_in_ready: got %h want 0", in_ready); end
    n_chk++; if (mix_valid !== 1'b0) begin n_err++; $display("FAIL rst_mix_valid: got %b want 0", mix_valid); end
    n_chk++; if (mix_data !== 16'h0 || mix_phase !== 32'h0) begin n_err++; $display("FAIL rst_mix_bus: got %h/%h want 0/0", mix_data, mix_phase); end
    n_chk++; if (out_valid !== 1'b0 || out_ch !== 2'd0) begin n_err++; $display("FAIL rst_out_tag: got %b/%0d want 0/0", out_valid, out_ch); end
    n_chk++; if (out_i !== 20'h0 || out_q !== 20'h0) begin n_err++; $display("FAIL rst_out_iq: got %h/%h want 0/0", out_i, out_q); end
    in_valid = '0; res_i = '0; res_q = '0;
    rst = 1'b0;
    #1;
    n_chk++; if (in_ready !== 4'hF) begin n_err++; $display("FAIL post_rst_in_ready: got %h want f", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_fword(2'd2, 32'h4000_0000);
    in_valid = 4'b0100; in_data[47:32] = 16'h1234;
    n_chk++; if (in_ready[2] !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", in_ready[2]); end
    tick();
    in_valid = '0;
    n_chk++; if (mix_valid !== 1'b0) begin n_err++; $display("FAIL single_early_issue: got %b want 0", mix_valid); end
    tick();
    n_chk++; if (mix_valid !== 1'b1 || mix_data !== 16'h1234 || mix_phase !== 32'h0) begin n_err++; $display("FAIL single_first: got v=%b d=%h p=%h want 1/1234/0", mix_valid, mix_data, mix_phase); end
    issue_one(2, 16'h5678);
    n_chk++; if (mix_valid !== 1'b1 || mix_data !== 16'h5678 || mix_phase !== 32'h4000_0000) begin n_err++; $display("FAIL single_second: got v=%b d=%h p=%h want 1/5678/40000000", mix_valid, mix_data, mix_phase); end
    tick();
    n_chk++; if (mix_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", mix_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    in_data = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    in_valid = 4'hF;
    tick();
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (in_ready !== (4'b0001 << (k % 4))) begin n_err++; $display("FAIL rr_ready_%0d: got %b want %b", k, in_ready, 4'b0001 << (k % 4)); end
      tick();
      n_chk++; if (mix_valid !== 1'b1 || mix_data !== 16'(16'h0100 + (k % 4))) begin n_err++; $display("FAIL rr_issue_%0d: got v=%b d=%h want 1/%h", k, mix_valid, mix_data, 16'h0100 + (k % 4)); end
    end
    in_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    set_fword(2'd0, 32'h8000_0001);
    issue_one(0, 16'h0001);
    n_chk++; if (mix_phase !== 32'h0) begin n_err++; $display("FAIL wrap_p0: got %h want 0", mix_phase); end
    issue_one(0, 16'h0002);
    n_chk++; if (mix_phase !== 32'h8000_0001) begin n_err++; $display("FAIL wrap_p1: got %h want 80000001", mix_phase); end
    issue_one(0, 16'h0003);
    n_chk++; if (mix_phase !== 32'h0000_0002) begin n_err++; $display("FAIL wrap_p2: got %h want 00000002", mix_phase); end
  endtask

  task automatic test_ph_clr();
    do_reset();
    set_fword(2'd1, 32'h0000_0100);
    issue_one(1, 16'h0011);
    in_valid = 4'b0010;
    tick();
    in_valid = '0;
    cfg_ph_clr = 1'b1; cfg_ch = 2'd1;   // same cycle as the channel 1 grant
    tick();
    cfg_ph_clr = 1'b0;
    n_chk++; if (mix_valid !== 1'b1 || mix_phase !== 32'h100) begin n_err++; $display("FAIL clr_old_phase: got v=%b p=%h want 1/100", mix_valid, mix_phase); end
    issue_one(1, 16'h0033);
    n_chk++; if (mix_phase !== 32'h0) begin n_err++; $display("FAIL clr_wins: got %h want 0", mix_phase); end
  endtask

  task automatic test_cfg_timing();
    do_reset();
    set_fword(2'd0, 32'h10);
    issue_one(0, 16'h00AA);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_fword = 32'h1000;  // lands with the grant
    tick();
    cfg_we = 1'b0;
    n_chk++; if (mix_phase !== 32'h10) begin n_err++; $display("FAIL cfg_p1: got %h want 10", mix_phase); end
    issue_one(0, 16'h00BB);
    n_chk++; if (mix_phase !== 32'h20) begin n_err++; $display("FAIL cfg_old_word: got %h want 20", mix_phase); end
    issue_one(0, 16'h00CC);
    n_chk++; if (mix_phase !== 32'h1020) begin n_err++; $display("FAIL cfg_new_word: got %h want 1020", mix_phase); end
  endtask

  task automatic test_pipe();
    do_reset();
    issue_one(3, 16'h0333);
    n_chk++; if (mix_valid !== 1'b1) begin n_err++; $display("FAIL pipe_issue: got %b want 1", mix_valid); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pipe_early_%0d: got %b want 0", k, out_valid); end
    end
    res_i = 20'h12345; res_q = 20'hABCDE;   // issue+3
    tick();
    res_i = '0; res_q = '0;
    n_chk++; if (out_valid !== 1'b1 || out_ch !== 2'd3) begin n_err++; $display("FAIL pipe_tag: got v=%b ch=%0d want 1/3", out_valid, out_ch); end
    n_chk++; if (out_i !== 20'h12345 || out_q !== 20'hABCDE) begin n_err++; $display("FAIL pipe_iq: got %h/%h want 12345/abcde", out_i, out_q); end
    tick();
    n_chk++; if (out_valid !== 1'b0 || out_i !== 20'h0) begin n_err++; $display("FAIL pipe_after: got v=%b i=%h want 0/0", out_valid, out_i); end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    in_valid = 4'b0001; in_data[15:0] = 16'h0E0E;
    tick();
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (mix_valid !== 1'b0 || in_ready[0] !== 1'b0) begin n_err++; $display("FAIL en_hold_%0d: got v=%b rdy=%b want 0/0", k, mix_valid, in_ready[0]); end
      tick();
    end
    en = 1'b1;
    #1;
    n_chk++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL en_grant_ready: got %b want 1", in_ready[0]); end
    tick();
    en = 1'b0;
    n_chk++; if (mix_valid !== 1'b1 || mix_data !== 16'h0E0E) begin n_err++; $display("FAIL en_retained: got v=%b d=%h want 1/0e0e", mix_valid, mix_data); end
    repeat (4) tick();
    n_chk++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin n_err++; $display("FAIL en_drain: got v=%b ch=%0d want 1/0", out_valid, out_ch); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 4'b0011;
    tick();
    in_valid = '0;
    tick(); tick();   // channels 0 and 1 now in flight
    rst = 1'b1;
    #1;
    n_chk++; if (in_ready !== 4'h0 || mix_valid !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_outs: got rdy=%h mv=%b ov=%b want 0/0/0", in_ready, mix_valid, out_valid); end
    n_chk++; if (mix_data !== 16'h0 || mix_phase !== 32'h0 || out_ch !== 2'd0) begin n_err++; $display("FAIL mid_rst_bus: got %h/%h/%0d want 0/0/0", mix_data, mix_phase, out_ch); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0 || mix_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_drain_%0d: got ov=%b mv=%b want 0/0", k, out_valid, mix_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_ph_clr();
    test_cfg_timing();
    test_pipe();
    test_enable();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
